// File: rtl/sm83_regpair_file.sv
// sm83_regpair_file: parametrised byte/pair register file with synchronous
// reset, optional write-through bypass on the read ports, and a three-state
// IDU sequencer that increments/decrements a pair low byte first, then the
// high byte with the registered carry/borrow.
module sm83_regpair_file #(
  parameter int unsigned   DW        = 8,
  parameter int unsigned   NPAIRS    = 4,
  parameter int unsigned   RPORTS    = 2,
  parameter int unsigned   BYPASS    = 0,
  parameter logic [DW-1:0] RESET_VAL = '0,
  localparam int unsigned  BSW       = $clog2(2 * NPAIRS),
  localparam int unsigned  PSW       = (NPAIRS > 1) ? $clog2(NPAIRS) : 1
) (
  input  logic                  CLK,
  input  logic                  SYNC_RES,
  input  logic                  wr_en,
  input  logic [BSW-1:0]        wr_sel,
  input  logic [DW-1:0]         wr_data,
  input  logic                  pw_en,
  input  logic [PSW-1:0]        pw_sel,
  input  logic [2*DW-1:0]       pw_data,
  input  logic [RPORTS*BSW-1:0] rd_sel,
  output logic [RPORTS*DW-1:0]  rd_data,
  input  logic [PSW-1:0]        pr_sel,
  output logic [2*DW-1:0]       pr_data,
  input  logic                  idu_start,
  input  logic [PSW-1:0]        idu_sel,
  input  logic                  idu_dec,
  output logic                  idu_busy,
  output logic                  idu_done,
  output logic [2*DW-1:0]       idu_result
);

  localparam int unsigned NREG = 2 * NPAIRS;

  typedef enum logic [1:0] {
    IDU_IDLE,
    IDU_LOW,
    IDU_HIGH
  } idu_state_e;

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [DW-1:0]   view   [NREG];

  idu_state_e      state_q, state_d;
  logic [DW-1:0]   snap_lo_q, snap_lo_d;
  logic [DW-1:0]   snap_hi_q, snap_hi_d;
  logic [PSW-1:0]  tgt_q, tgt_d;
  logic            dec_q, dec_d;
  logic            carry_q, carry_d;
  logic [2*DW-1:0] result_q, result_d;
  logic            done_q, done_d;

  logic [DW-1:0]   idu_op_lo, idu_op_hi;
  logic [DW-1:0]   lo_new, hi_new;
  logic            commit_en, commit_hi;
  logic [DW-1:0]   commit_val;

  // Operand fetch for a starting IDU op: the addressed pair straight from storage.
  always_comb begin
    idu_op_lo = '0;
    idu_op_hi = '0;
    for (int unsigned p = 0; p < NPAIRS; p++) begin
      if (32'(idu_sel) == p) begin
        idu_op_lo = regs_q[2*p];
        idu_op_hi = regs_q[2*p+1];
      end
    end
  end

  // IDU byte arithmetic on the snapshot; carry is the registered low-byte carry/borrow.
  always_comb begin
    lo_new = dec_q ? (snap_lo_q - DW'(1)) : (snap_lo_q + DW'(1));
    hi_new = dec_q ? (snap_hi_q - DW'(carry_q)) : (snap_hi_q + DW'(carry_q));
  end

  // IDU next-state and byte-commit selection.
  always_comb begin
    state_d    = state_q;
    snap_lo_d  = snap_lo_q;
    snap_hi_d  = snap_hi_q;
    tgt_d      = tgt_q;
    dec_d      = dec_q;
    carry_d    = carry_q;
    result_d   = result_q;
    done_d     = 1'b0;
    commit_en  = 1'b0;
    commit_hi  = 1'b0;
    commit_val = '0;
    case (state_q)
      IDU_IDLE: begin
        if (idu_start) begin
          state_d   = IDU_LOW;
          snap_lo_d = idu_op_lo;
          snap_hi_d = idu_op_hi;
          tgt_d     = idu_sel;
          dec_d     = idu_dec;
        end
      end
      IDU_LOW: begin
        state_d    = IDU_HIGH;
        commit_en  = 1'b1;
        commit_val = lo_new;
        carry_d    = dec_q ? (snap_lo_q == '0) : (snap_lo_q == '1);
      end
      IDU_HIGH: begin
        state_d    = IDU_IDLE;
        commit_en  = 1'b1;
        commit_hi  = 1'b1;
        commit_val = hi_new;
        result_d   = {hi_new, lo_new};
        done_d     = 1'b1;
      end
      default: state_d = IDU_IDLE;
    endcase
  end

  // Storage update: byte write, then pair write (wins on overlap), then IDU commit
  // (wins over both). Selects matching no register write nothing.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (32'(wr_sel) == i)) begin
        regs_d[i] = wr_data;
      end
      if (pw_en && (32'(pw_sel) == i / 2)) begin
        regs_d[i] = (i % 2 == 1) ? pw_data[2*DW-1:DW] : pw_data[DW-1:0];
      end
      if (commit_en && (32'(tgt_q) == i / 2) && ((i % 2 == 1) == commit_hi)) begin
        regs_d[i] = commit_val;
      end
    end
  end

  // Read view: storage, optionally overlaid with this cycle's external writes.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      view[i] = regs_q[i];
      if (BYPASS != 0) begin
        if (wr_en && (32'(wr_sel) == i)) begin
          view[i] = wr_data;
        end
        if (pw_en && (32'(pw_sel) == i / 2)) begin
          view[i] = (i % 2 == 1) ? pw_data[2*DW-1:DW] : pw_data[DW-1:0];
        end
      end
    end
  end

  // Asynchronous byte and pair read muxes.
  always_comb begin
    rd_data = '0;
    pr_data = '0;
    for (int unsigned k = 0; k < RPORTS; k++) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (32'(rd_sel[k*BSW +: BSW]) == i) begin
          rd_data[k*DW +: DW] = view[i];
        end
      end
    end
    for (int unsigned p = 0; p < NPAIRS; p++) begin
      if (32'(pr_sel) == p) begin
        pr_data = {view[2*p+1], view[2*p]};
      end
    end
  end

  // State registers; reset overrides every write and start in the same cycle.
  always_ff @(posedge CLK) begin
    if (SYNC_RES) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= RESET_VAL;
      end
      state_q   <= IDU_IDLE;
      snap_lo_q <= '0;
      snap_hi_q <= '0;
      tgt_q     <= '0;
      dec_q     <= 1'b0;
      carry_q   <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      state_q   <= state_d;
      snap_lo_q <= snap_lo_d;
      snap_hi_q <= snap_hi_d;
      tgt_q     <= tgt_d;
      dec_q     <= dec_d;
      carry_q   <= carry_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign idu_busy   = (state_q != IDU_IDLE);
  assign idu_done   = done_q;
  assign idu_result = result_q;

endmodule
